mult_product_accumulator: RTL and testbench

Downstream consumer of the 4-bit array multiplier's 8-bit product Z. It accumulates a stream of products into a dot-product sum, using a valid/ready input handshake. A group closes after LEN products or early on in_last. The result is then held on a valid/ready output until the sink accepts it. This block turns the combinational multiplier into a registered MAC datapath.

---
 rtl/mult_product_accumulator.sv | 112 +++++++++++
 tb/tb_mult_product_accumulator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mult_product_accumulator.sv
// Registered multiply-accumulate back end: sums a stream of 8-bit multiplier
// products into per-group dot-product results behind valid/ready handshakes.
module mult_product_accumulator #(
    parameter int unsigned LEN   = 4,
    parameter int unsigned ACC_W = 10,
    parameter int unsigned CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {
        ST_ACC,
        ST_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               accept;
    logic               close_grp;
    logic [ACC_W:0]     sum;
    logic [CNT_W-1:0]   cnt_inc;

    assign in_ready  = (state_q == ST_ACC) && !rst;
    assign accept    = in_valid && in_ready;
    // Bit ACC_W of the widened sum is the carry that feeds the sticky overflow.
    assign sum       = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(in_product);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign close_grp = (cnt_q == CNT_W'(LEN - 1)) || in_last;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (close_grp) begin
                        out_data_d  = sum[ACC_W-1:0];
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_q | sum[ACC_W];
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | sum[ACC_W];
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Bench for mult_product_accumulator: a 10-bit and an 8-bit accumulator share
// one stimulus stream and are checked against an arithmetic group model.
module tb_mult_product_accumulator;

    localparam int unsigned LEN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_product;
    logic       in_last;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_ovf_a;
    logic [9:0] out_data_a;
    logic [2:0] out_count_a;
    logic       in_ready_b, out_valid_b, out_ovf_b;
    logic [7:0] out_data_b;
    logic [2:0] out_count_b;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integer sum and beat count of the open group.
    int grp_sum = 0;
    int grp_cnt = 0;
    bit grp_closed = 1'b0;

    always #5 clk = ~clk;

    mult_product_accumulator #(.LEN(LEN), .ACC_W(10)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_product(in_product), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_count(out_count_a), .out_ovf(out_ovf_a)
    );

    mult_product_accumulator #(.LEN(LEN), .ACC_W(8)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_product(in_product), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Idle cycles drive junk product/last with in_valid low; none may be absorbed.
    task automatic beat(input int p, input bit last, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid   = 1'b0;
            in_product = 8'($urandom_range(0, 255));
            in_last    = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid   = 1'b1;
        in_product = 8'(p);
        in_last    = last;
        chk("beat_in_ready_a", 32'(in_ready_a), 32'd1);
        chk("beat_in_ready_b", 32'(in_ready_b), 32'd1);
        @(posedge clk);
        grp_sum += p;
        grp_cnt++;
        if (last || grp_cnt == LEN) grp_closed = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_valid_a"}, 32'(out_valid_a), 32'd1);
        chk({tag, "_valid_b"}, 32'(out_valid_b), 32'd1);
        chk({tag, "_data_a"},  32'(out_data_a),  32'(grp_sum % 1024));
        chk({tag, "_data_b"},  32'(out_data_b),  32'(grp_sum % 256));
        chk({tag, "_count_a"}, 32'(out_count_a), 32'(grp_cnt));
        chk({tag, "_count_b"}, 32'(out_count_b), 32'(grp_cnt));
        chk({tag, "_ovf_a"},   32'(out_ovf_a),   32'(grp_sum > 1023));
        chk({tag, "_ovf_b"},   32'(out_ovf_b),   32'(grp_sum > 255));
        chk({tag, "_in_ready_out"}, 32'(in_ready_a | in_ready_b), 32'd0);
    endtask

    // Hold the result under backpressure (optionally with offered beats), then drain it.
    task automatic take_result(input string tag, input int hold, input bit inject);
        check_result(tag);
        for (int h = 0; h < hold; h++) begin
            in_valid   = inject;
            in_product = 8'd99;
            out_ready  = 1'b0;
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid_a & out_valid_b), 32'd1);
            chk({tag, "_hold_data_a"}, 32'(out_data_a), 32'(grp_sum % 1024));
            chk({tag, "_hold_data_b"}, 32'(out_data_b), 32'(grp_sum % 256));
            chk({tag, "_hold_in_ready"}, 32'(in_ready_a | in_ready_b), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 32'(out_valid_a | out_valid_b), 32'd0);
        chk({tag, "_drain_in_ready"}, 32'(in_ready_a & in_ready_b), 32'd1);
        chk({tag, "_keep_data_a"}, 32'(out_data_a), 32'(grp_sum % 1024));
        chk({tag, "_keep_count_a"}, 32'(out_count_a), 32'(grp_cnt));
        grp_sum    = 0;
        grp_cnt    = 0;
        grp_closed = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_a | in_ready_b), 32'd0);
        chk("rst_valid", 32'(out_valid_a | out_valid_b), 32'd0);
        chk("rst_data_a", 32'(out_data_a), 32'd0);
        chk("rst_count_a", 32'(out_count_a), 32'd0);
        chk("rst_ovf", 32'(out_ovf_a | out_ovf_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready_a & in_ready_b), 32'd1);
        grp_sum    = 0;
        grp_cnt    = 0;
        grp_closed = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_product = 8'd0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        pulse_reset();

        // Full-scale group: 4 x 225 = 900 fits in 10 bits, wraps to 132 in 8 bits.
        for (int i = 0; i < 4; i++) beat(225, 1'b0, 0);
        take_result("full", 0, 1'b0);

        // Early close on in_last, then a fresh group proves the accumulator cleared.
        beat(6, 1'b0, 0);
        beat(12, 1'b1, 0);
        take_result("early", 1, 1'b0);
        for (int i = 0; i < 4; i++) beat(1, 1'b0, 0);
        take_result("ones", 0, 1'b0);

        // Backpressure with beats of 99 offered while the result is held.
        for (int i = 1; i <= 4; i++) beat(i, 1'b0, 0);
        take_result("bp", 5, 1'b1);

        // Gapped beats with junk in_last during the idle cycles; last on 4th beat.
        for (int i = 1; i <= 4; i++) beat(i, (i == 4), 2);
        take_result("gap", 0, 1'b0);

        // Zero products still count.
        beat(0, 1'b0, 0);
        beat(0, 1'b1, 0);
        take_result("zero", 0, 1'b0);

        // Reset mid-group discards the partial sum.
        beat(200, 1'b0, 0);
        beat(200, 1'b0, 0);
        pulse_reset();
        for (int i = 0; i < 4; i++) beat(1, 1'b0, 0);
        take_result("after_rst", 0, 1'b0);

        // Reset while holding a result drops it.
        for (int i = 0; i < 4; i++) beat(50, 1'b0, 0);
        check_result("pre_rst_out");
        pulse_reset();

        // Randomized groups.
        for (int g = 0; g < 25; g++) begin
            while (!grp_closed) begin
                beat(int'($urandom_range(0, 225)), ($urandom_range(0, 4) == 0),
                     int'($urandom_range(0, 2)));
            end
            take_result("rand", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
